// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED sequence controller: display modes and FSM states.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Modes other than OFF keep the divider running after APPLY.
    function automatic logic mode_is_active(mode_e m);
        return (m != MODE_OFF);
    endfunction

    // WALK and BOUNCE start with only the LSB lit; OFF and BLINK start dark.
    function automatic logic mode_starts_lit(mode_e m);
        return (m == MODE_WALK) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Tick divider: counts 0..period while run is high and emits a registered
// one-cycle tick in the cycle where the counter sits at period.
module tick_gen #(
    parameter int CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] period,
    input  logic             run,
    input  logic             clr,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;

    // Counter and tick register; clr or a stopped divider parks both at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr || !run) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            // Tick is registered one count early so it is high while r_cnt == period.
            r_tick <= (r_cnt == (period - ONE));
            r_cnt  <= (r_cnt >= period) ? '0 : (r_cnt + ONE);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequence controller: accepts mode/period configs over a valid/ready
// port and steps a bank of LEDs through OFF, BLINK, WALK or BOUNCE patterns.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int LED_NUM = 4,
    parameter int CNT_W   = 26
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_period,
    output logic               cfg_ready,
    output logic [LED_NUM-1:0] led,
    output logic               tick,
    output logic [1:0]         mode_cur,
    output logic               busy
);

    localparam logic [CNT_W-1:0]   PERIOD_MIN = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] LED_LSB    = {{(LED_NUM-1){1'b0}}, 1'b1};

    state_e             r_state;
    mode_e              r_mode;
    logic [1:0]         r_mode_cur;
    logic [LED_NUM-1:0] r_led;
    logic               r_dir_up;
    logic               r_cfg_ready;
    logic               r_busy;
    logic [CNT_W-1:0]   r_period;

    logic               w_accept;
    logic               w_tick;
    logic               w_run;
    logic [CNT_W-1:0]   w_period_clamped;
    logic [LED_NUM-1:0] w_rot_l;
    logic [LED_NUM-1:0] w_shl;
    logic [LED_NUM-1:0] w_shr;
    logic [LED_NUM-1:0] w_led_step;
    logic [LED_NUM-1:0] w_led_init;
    logic               w_dir_up_next;

    // ready is only ever high in IDLE or RUN, so this also gates on state
    assign w_accept         = cfg_valid && r_cfg_ready && (r_state != ST_APPLY);
    assign w_run            = (r_state == ST_RUN);
    assign w_period_clamped = (cfg_period == '0) ? PERIOD_MIN : cfg_period;
    assign w_led_init       = mode_starts_lit(r_mode) ? LED_LSB : '0;

    // Clearing on the accept edge keeps tick low throughout APPLY.
    tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (sclk),
        .rst_n  (rst_n),
        .period (r_period),
        .run    (w_run),
        .clr    (w_accept),
        .tick   (w_tick)
    );

    // Per-bit neighbours: rotate-left, shift toward MSB, shift toward LSB.
    genvar gi;
    generate
        for (gi = 0; gi < LED_NUM; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign w_rot_l[gi] = r_led[LED_NUM-1];
                assign w_shl[gi]   = 1'b0;
            end else begin : g_not_lsb
                assign w_rot_l[gi] = r_led[gi-1];
                assign w_shl[gi]   = r_led[gi-1];
            end
            if (gi == LED_NUM - 1) begin : g_msb
                assign w_shr[gi] = 1'b0;
            end else begin : g_not_msb
                assign w_shr[gi] = r_led[gi+1];
            end
        end
    endgenerate

    // Next LED pattern for a tick; BOUNCE turns around on reaching either end.
    always_comb begin
        w_dir_up_next = r_dir_up;
        w_led_step    = r_led;
        case (r_mode)
            MODE_BLINK: w_led_step = ~r_led;
            MODE_WALK:  w_led_step = w_rot_l;
            MODE_BOUNCE: begin
                if (r_dir_up && r_led[LED_NUM-1]) begin
                    w_dir_up_next = 1'b0;
                end else if (!r_dir_up && r_led[0]) begin
                    w_dir_up_next = 1'b1;
                end
                w_led_step = w_dir_up_next ? w_shl : w_shr;
            end
            default: w_led_step = r_led;
        endcase
    end

    // Control FSM: accept configs, apply initial pattern, step LEDs on ticks.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_OFF;
            r_mode_cur  <= 2'd0;
            r_led       <= '0;
            r_dir_up    <= 1'b1;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_period    <= PERIOD_MIN;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_accept) begin
                        // a tick ending on this edge is dropped: config wins
                        r_period    <= w_period_clamped;
                        r_mode      <= mode_e'(cfg_mode);
                        r_mode_cur  <= cfg_mode;
                        r_cfg_ready <= 1'b0;
                        r_state     <= ST_APPLY;
                    end else if ((r_state == ST_RUN) && w_tick) begin
                        r_led    <= w_led_step;
                        r_dir_up <= w_dir_up_next;
                    end
                end
                ST_APPLY: begin
                    r_cfg_ready <= 1'b1;
                    r_led       <= w_led_init;
                    r_dir_up    <= 1'b1;
                    r_busy      <= mode_is_active(r_mode);
                    r_state     <= mode_is_active(r_mode) ? ST_RUN : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign led       = r_led;
    assign tick      = w_tick;
    assign mode_cur  = r_mode_cur;
    assign busy      = r_busy;

endmodule
